sparrow_dmem_resp: RTL and testbench

Data-memory responder for the sparrow core. It sits on the far end of the core's `dmem` port and serves loads and stores from an internal word-organised SRAM. It decodes the access size, extracts or merges byte lanes and flags illegal accesses. It also provides a sticky `tohost` halt register so benches and FPGA top levels can detect program completion.

---
 rtl/sparrow_pkg.sv | 31 +++
 rtl/sparrow_sram_1rw.sv | 33 +++
 rtl/sparrow_dmem_resp.sv | 162 ++++++++++++++++
 tb/tb_sparrow_dmem_resp.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sparrow_pkg.sv
// Shared definitions for the sparrow core and its memory-side responders.
// The load/store unit and the data-memory responder both use the access
// size encoding and the byte-lane mask helper defined here.
package sparrow_pkg;

   // Access size carried on the dmem byte_en field
   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10,
      MEM_RSVD = 2'b11
   } mem_size_e;

   // Source of the load data returned one cycle after a load request
   typedef enum logic [1:0] {
      RD_ZERO   = 2'b00,
      RD_SRAM   = 2'b01,
      RD_TOHOST = 2'b10
   } rd_sel_e;

   // Byte-lane mask for an access of the given size, before lane shifting
   function automatic logic [3:0] size_mask(input mem_size_e size);
      case (size)
         MEM_BYTE: size_mask = 4'b0001;
         MEM_HALF: size_mask = 4'b0011;
         MEM_WORD: size_mask = 4'b1111;
         default:  size_mask = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/sparrow_sram_1rw.sv
// Single-port word SRAM with per-byte write strobes and a registered read
// port. No reset on the array or the read register so the whole thing maps
// onto a block RAM. The read register only updates on a read (enable with
// no strobes), so the last read word stays put across writes and idles.
module sparrow_sram_1rw #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          i_clk,
   input  logic          i_en,
   input  logic [3:0]    i_wr_strb,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wr_data,
   output logic [31:0]   o_rd_data
);

   logic [31:0] mem [DEPTH_WORDS];

   // Byte-masked write, or a registered read when no lane is strobed
   always_ff @(posedge i_clk) begin
      if (i_en) begin
         for (int b = 0; b < 4; b++) begin
            if (i_wr_strb[b]) begin
               mem[i_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
            end
         end
         if (i_wr_strb == 4'b0000) begin
            o_rd_data <= mem[i_addr];
         end
      end
   end

endmodule

// File: rtl/sparrow_dmem_resp.sv
// Data-memory responder on the far end of the sparrow dmem port. Decodes
// size and address, merges store lanes into the SRAM, extracts load lanes
// from the registered read word, flags illegal accesses and holds the
// sticky tohost halt register plus load/store counters.
module sparrow_dmem_resp
   import sparrow_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
   parameter logic [31:0] TOHOST_ADDR = 32'hFFFF_FFF0
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_dmem_req,
   input  logic [31:0] i_dmem_addr,
   input  logic [1:0]  i_dmem_byte_en,
   input  logic        i_dmem_wr_en,
   input  logic [31:0] i_dmem_wr_data,
   output logic [31:0] o_dmem_rd_data,
   output logic        o_fault,
   output logic        o_halt,
   output logic [31:0] o_exit_code,
   output logic [31:0] o_ld_count,
   output logic [31:0] o_st_count
);

   localparam int          AW       = $clog2(DEPTH_WORDS);
   // One past the last SRAM byte; 33 bits so a range ending at 4 GiB still compares
   localparam logic [32:0] SRAM_END = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

   // Load mask applied after the lane shift; the core sign-extends
   function automatic logic [31:0] load_mask(input mem_size_e size);
      case (size)
         MEM_BYTE: load_mask = 32'h0000_00FF;
         MEM_HALF: load_mask = 32'h0000_FFFF;
         MEM_WORD: load_mask = 32'hFFFF_FFFF;
         default:  load_mask = 32'h0000_0000;
      endcase
   endfunction

   // ---- stage p0: request decode, combinational from the inputs ----
   mem_size_e   size_p0;
   logic        sram_hit_p0;
   logic        tohost_hit_p0;
   logic        aligned_p0;
   logic        legal_p0;
   logic        acc_ld_p0;
   logic        acc_st_p0;
   logic        fault_p0;
   logic        sram_en_p0;
   logic [3:0]  strb_p0;
   logic [31:0] wdata_p0;

   assign size_p0       = mem_size_e'(i_dmem_byte_en);
   assign sram_hit_p0   = ({1'b0, i_dmem_addr} >= {1'b0, BASE_ADDR}) &&
                          ({1'b0, i_dmem_addr} <  SRAM_END);
   assign tohost_hit_p0 = (i_dmem_addr == TOHOST_ADDR) && (size_p0 == MEM_WORD);
   assign legal_p0      = (sram_hit_p0 || tohost_hit_p0) && aligned_p0;
   assign acc_ld_p0     = i_dmem_req && !i_dmem_wr_en && legal_p0;
   assign acc_st_p0     = i_dmem_req &&  i_dmem_wr_en && legal_p0;
   assign fault_p0      = i_dmem_req && !legal_p0;
   assign sram_en_p0    = i_dmem_req && legal_p0 && sram_hit_p0;

   // Alignment rule per size; the reserved size is never legal
   always_comb begin
      aligned_p0 = 1'b0;
      case (size_p0)
         MEM_BYTE: aligned_p0 = 1'b1;
         MEM_HALF: aligned_p0 = !i_dmem_addr[0];
         MEM_WORD: aligned_p0 = (i_dmem_addr[1:0] == 2'b00);
         default:  aligned_p0 = 1'b0;
      endcase
   end

   // Store strobe and lane-replicated store data
   always_comb begin
      strb_p0  = 4'b0000;
      wdata_p0 = i_dmem_wr_data;
      if (acc_st_p0 && sram_hit_p0) begin
         strb_p0 = size_mask(size_p0) << i_dmem_addr[1:0];
      end
      case (size_p0)
         MEM_BYTE: wdata_p0 = {4{i_dmem_wr_data[7:0]}};
         MEM_HALF: wdata_p0 = {2{i_dmem_wr_data[15:0]}};
         default:  wdata_p0 = i_dmem_wr_data;
      endcase
   end

   // ---- stage p1: SRAM read word and load-extract controls ----
   logic [31:0] sram_q_p1;
   rd_sel_e     rd_sel_p1;
   logic [1:0]  rd_off_p1;
   mem_size_e   rd_size_p1;
   logic        rd_halt_p1;

   sparrow_sram_1rw #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_sram (
      .i_clk     (i_clk),
      .i_en      (sram_en_p0),
      .i_wr_strb (strb_p0),
      .i_addr    (i_dmem_addr[AW+1:2]),
      .i_wr_data (wdata_p0),
      .o_rd_data (sram_q_p1)
   );

   // Capture what the next load result is built from; only loads update it
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rd_sel_p1  <= RD_ZERO;
         rd_off_p1  <= 2'b00;
         rd_size_p1 <= MEM_BYTE;
         rd_halt_p1 <= 1'b0;
      end else if (i_dmem_req && !i_dmem_wr_en) begin
         if (!legal_p0) begin
            rd_sel_p1 <= RD_ZERO;
         end else if (tohost_hit_p0) begin
            rd_sel_p1 <= RD_TOHOST;
         end else begin
            rd_sel_p1 <= RD_SRAM;
         end
         rd_off_p1  <= i_dmem_addr[1:0];
         rd_size_p1 <= size_p0;
         rd_halt_p1 <= o_halt;
      end
   end

   // Load data: shift the selected lane down, then mask to the access size
   always_comb begin
      o_dmem_rd_data = 32'h0000_0000;
      case (rd_sel_p1)
         RD_SRAM:   o_dmem_rd_data = (sram_q_p1 >> {rd_off_p1, 3'b000}) & load_mask(rd_size_p1);
         RD_TOHOST: o_dmem_rd_data = {31'b0, rd_halt_p1};
         default:   o_dmem_rd_data = 32'h0000_0000;
      endcase
   end

   // Fault pulse, sticky tohost halt and access counters
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_fault     <= 1'b0;
         o_halt      <= 1'b0;
         o_exit_code <= 32'h0000_0000;
         o_ld_count  <= 32'h0000_0000;
         o_st_count  <= 32'h0000_0000;
      end else begin
         o_fault <= fault_p0;
         if (acc_ld_p0) begin
            o_ld_count <= o_ld_count + 32'd1;
         end
         if (acc_st_p0) begin
            o_st_count <= o_st_count + 32'd1;
         end
         if (acc_st_p0 && tohost_hit_p0 && !o_halt) begin
            o_halt      <= 1'b1;
            o_exit_code <= i_dmem_wr_data;
         end
      end
   end

endmodule

// File: tb/tb_sparrow_dmem_resp.sv
// Directed bench for sparrow_dmem_resp: a table of single accesses with
// hand-computed results, followed by back-to-back and async-reset sequences.
module tb_sparrow_dmem_resp;

   logic        clk;
   logic        rst_n;
   logic        req;
   logic [31:0] addr;
   logic [1:0]  size;
   logic        wr;
   logic [31:0] wdata;
   logic [31:0] rd_data;
   logic        fault;
   logic        halt;
   logic [31:0] exit_code;
   logic [31:0] ld_count;
   logic [31:0] st_count;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_R = 2'b11;

   sparrow_dmem_resp #(
      .DEPTH_WORDS (1024),
      .BASE_ADDR   (32'h0000_2000),
      .TOHOST_ADDR (32'hFFFF_FFF0)
   ) dut (
      .i_clk          (clk),
      .i_reset_n      (rst_n),
      .i_dmem_req     (req),
      .i_dmem_addr    (addr),
      .i_dmem_byte_en (size),
      .i_dmem_wr_en   (wr),
      .i_dmem_wr_data (wdata),
      .o_dmem_rd_data (rd_data),
      .o_fault        (fault),
      .o_halt         (halt),
      .o_exit_code    (exit_code),
      .o_ld_count     (ld_count),
      .o_st_count     (st_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_fault;
      logic [31:0] exp_ld;
      logic [31:0] exp_st;
      logic        exp_halt;
      logic [31:0] exp_exit;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] rd, input logic f, input logic [31:0] lc, input logic [31:0] sc,
                      input logic h, input logic [31:0] ec);
      vec_t v;
      v.wr = w; v.size = s; v.addr = a; v.wdata = d;
      v.exp_rd = rd; v.exp_fault = f; v.exp_ld = lc; v.exp_st = sc;
      v.exp_halt = h; v.exp_exit = ec;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Present one request, let it be sampled, return 1 time unit after the edge
   task automatic issue(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
      req = 1'b1; wr = w; size = s; addr = a; wdata = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req = 1'b0; wr = 1'b0; size = SZ_B; addr = 32'h0; wdata = 32'h0;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " rd_data"},   rd_data,   32'h0);
      chk({tag, " fault"},     {31'b0, fault}, 32'h0);
      chk({tag, " halt"},      {31'b0, halt},  32'h0);
      chk({tag, " exit_code"}, exit_code, 32'h0);
      chk({tag, " ld_count"},  ld_count,  32'h0);
      chk({tag, " st_count"},  st_count,  32'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      req = 1'b0; wr = 1'b0; size = SZ_B; addr = 32'h0; wdata = 32'h0;

      //   wr  size  addr          wdata         exp_rd        flt ld  st  halt exit
      add(1, SZ_W, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0000_0000, 0, 0,  1, 0, 32'h0);
      add(0, SZ_W, 32'h0000_2000, 32'h0,         32'hDEAD_BEEF, 0, 1,  1, 0, 32'h0);
      add(1, SZ_W, 32'h0000_2004, 32'h1122_3344, 32'hDEAD_BEEF, 0, 1,  2, 0, 32'h0);
      add(1, SZ_B, 32'h0000_2006, 32'h0000_00AA, 32'hDEAD_BEEF, 0, 1,  3, 0, 32'h0);
      add(1, SZ_H, 32'h0000_2004, 32'h0000_BBCC, 32'hDEAD_BEEF, 0, 1,  4, 0, 32'h0);
      add(0, SZ_W, 32'h0000_2004, 32'h0,         32'h11AA_BBCC, 0, 2,  4, 0, 32'h0);
      add(0, SZ_B, 32'h0000_2007, 32'h0,         32'h0000_0011, 0, 3,  4, 0, 32'h0);
      add(0, SZ_H, 32'h0000_2006, 32'h0,         32'h0000_11AA, 0, 4,  4, 0, 32'h0);
      add(1, SZ_H, 32'h0000_2001, 32'h0000_FFFF, 32'h0000_11AA, 1, 4,  4, 0, 32'h0);
      add(0, SZ_W, 32'h0000_2002, 32'h0,         32'h0000_0000, 1, 4,  4, 0, 32'h0);
      add(0, SZ_W, 32'h0000_1FFC, 32'h0,         32'h0000_0000, 1, 4,  4, 0, 32'h0);
      add(1, SZ_W, 32'h0000_1FFC, 32'h1234_5678, 32'h0000_0000, 1, 4,  4, 0, 32'h0);
      add(0, SZ_R, 32'h0000_2004, 32'h0,         32'h0000_0000, 1, 4,  4, 0, 32'h0);
      add(0, SZ_W, 32'h0000_2004, 32'h0,         32'h11AA_BBCC, 0, 5,  4, 0, 32'h0);
      add(0, SZ_W, 32'h0000_2000, 32'h0,         32'hDEAD_BEEF, 0, 6,  4, 0, 32'h0);
      add(1, SZ_W, 32'h0000_2FFC, 32'hCAFE_F00D, 32'hDEAD_BEEF, 0, 6,  5, 0, 32'h0);
      add(0, SZ_W, 32'h0000_2FFC, 32'h0,         32'hCAFE_F00D, 0, 7,  5, 0, 32'h0);
      add(0, SZ_W, 32'h0000_3000, 32'h0,         32'h0000_0000, 1, 7,  5, 0, 32'h0);
      add(0, SZ_W, 32'hFFFF_FFF0, 32'h0,         32'h0000_0000, 0, 8,  5, 0, 32'h0);
      add(1, SZ_W, 32'hFFFF_FFF0, 32'h0000_002A, 32'h0000_0000, 0, 8,  6, 1, 32'h2A);
      add(1, SZ_W, 32'hFFFF_FFF0, 32'h0000_0007, 32'h0000_0000, 0, 8,  7, 1, 32'h2A);
      add(0, SZ_W, 32'hFFFF_FFF0, 32'h0,         32'h0000_0001, 0, 9,  7, 1, 32'h2A);
      add(1, SZ_B, 32'hFFFF_FFF0, 32'h0000_0055, 32'h0000_0001, 1, 9,  7, 1, 32'h2A);
      add(0, SZ_B, 32'h0000_2000, 32'h0,         32'h0000_00EF, 0, 10, 7, 1, 32'h2A);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Table: one access, check its result slot, then one idle cycle
      foreach (vecs[i]) begin
         issue(vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata);
         chk($sformatf("v%0d rd_data", i),   rd_data,   vecs[i].exp_rd);
         chk($sformatf("v%0d fault", i),     {31'b0, fault}, {31'b0, vecs[i].exp_fault});
         chk($sformatf("v%0d ld_count", i),  ld_count,  vecs[i].exp_ld);
         chk($sformatf("v%0d st_count", i),  st_count,  vecs[i].exp_st);
         chk($sformatf("v%0d halt", i),      {31'b0, halt}, {31'b0, vecs[i].exp_halt});
         chk($sformatf("v%0d exit_code", i), exit_code, vecs[i].exp_exit);
         idle();
         chk($sformatf("v%0d idle fault", i), {31'b0, fault}, 32'h0);
         chk($sformatf("v%0d idle rd_hold", i), rd_data, vecs[i].exp_rd);
      end

      // Back-to-back store then load of the same word, no idle between
      issue(1'b1, SZ_W, 32'h0000_2010, 32'h0000_0005);
      issue(1'b0, SZ_W, 32'h0000_2010, 32'h0);
      chk("b2b rd_data",  rd_data,  32'h0000_0005);
      chk("b2b fault",    {31'b0, fault}, 32'h0);
      chk("b2b ld_count", ld_count, 32'd11);
      chk("b2b st_count", st_count, 32'd8);

      // Async reset dropped mid-cycle during a load stream
      issue(1'b0, SZ_W, 32'h0000_2000, 32'h0);
      chk("stream ld0", rd_data, 32'hDEAD_BEEF);
      issue(1'b0, SZ_W, 32'h0000_2004, 32'h0);
      chk("stream ld1", rd_data, 32'h11AA_BBCC);
      #1;
      rst_n = 1'b0;
      req = 1'b0;
      #1;
      chk_all_zero("async");
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_all_zero("post_release");
      issue(1'b0, SZ_W, 32'h0000_2000, 32'h0);
      chk("post ld 2000", rd_data, 32'hDEAD_BEEF);
      issue(1'b0, SZ_W, 32'h0000_2FFC, 32'h0);
      chk("post ld 2FFC", rd_data, 32'hCAFE_F00D);
      issue(1'b0, SZ_H, 32'h0000_2004, 32'h0);
      chk("post ld 2004 half", rd_data, 32'h0000_BBCC);
      chk("post ld_count", ld_count, 32'd3);
      chk("post st_count", st_count, 32'd0);
      idle();
      chk("post halt", {31'b0, halt}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
